axis_red_pitaya_adc_mc: RTL and testbench
=========================================

// Module: axis_red_pitaya_adc_mc
// PURPOSE
//  Multi-channel successor of the single-channel Red Pitaya ADC AXI-Stream source. Each cycle it registers NUM_CH
//  free-running ADC words and converts offset-binary to sign-extended two's complement. It can boxcar-decimate
//  (sum of N samples, arithmetic shift, saturate) and buffers output beats in a FIFO, because the ADC cannot stall.
//  Overflow is reported through a sticky flag and a drop counter; feeds DSP/DMA AXI-Stream chain.
// PARAMETERS
//  NUM_CH          2   number of ADC channels, packed in one beat
//  ADC_DATA_WIDTH  14  bits per ADC channel (offset binary)
//  AXIS_DATA_WIDTH 16  bits per channel lane on m_axis_tdata (>= ADC_DATA_WIDTH)
//  DECIM_WIDTH     8   width of decim ratio input; ACC_W = ADC_DATA_WIDTH+DECIM_WIDTH
//  FIFO_DEPTH      16  beats of buffering, power of 2, >= 4
//  COUNT_WIDTH     32  width of drop_count
// PORTS
//  aclk          in   1                         clock
//  aresetn       in   1                         synchronous active-low reset
//  adc_in        in   NUM_CH*ADC_DATA_WIDTH     ch k at [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
//  enable        in   1                         1 = acquire; 0 = hold decimator idle, FIFO still drains
//  decim         in   DECIM_WIDTH               samples per output beat; 0 treated as 1
//  shift         in   $clog2(ACC_W)             arithmetic right shift applied to block sum
//  clear_ovf     in   1                         pulse: clears overflow and drop_count
//  m_axis_tdata  out  NUM_CH*AXIS_DATA_WIDTH    ch k at [k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]
//  m_axis_tvalid out  1                         FIFO non-empty
//  m_axis_tready in   1                         downstream accept
//  overflow      out  1                         sticky: a beat was dropped
//  drop_count    out  COUNT_WIDTH               dropped beats, saturating
//  fifo_level    out  $clog2(FIFO_DEPTH)+1      occupied FIFO entries
// BEHAVIOUR
//  Reset (aresetn=0 at edge)
//  - all state cleared; tvalid=0, tdata=0, overflow=0, drop_count=0, fifo_level=0.
//  - a reset mid-block discards the partial sum; FIFO contents are lost.
//  Stage 0: adc_reg <= adc_in every cycle; never stalls.
//  Stage 1: conv = {~msb, rest} sign-extended to ACC_W; acc per channel.
//  Decimation
//  - Counter cnt runs 0..N-1; N and shift are latched at cnt==0, so changes apply at the next block only.
//  - cnt==0: acc <= conv. Otherwise acc <= acc + conv.
//  - At cnt==N-1 a block completes; the result is computed from the final sum, including the current sample.
//  - Result = (sum >>> shift), saturated to [-2^(AXIS_DATA_WIDTH-1), 2^(AXIS_DATA_WIDTH-1)-1] per channel.
//  - ACC_W guarantees the sum never wraps.
//  - enable=0: cnt <= 0, acc discarded, no FIFO writes. The next block starts on the first enabled sample.
//  Stage 2: the block result is written to the FIFO as one beat (all channels).
//  Latency: with N=1 and FIFO empty, a sample on adc_in at edge E is on tdata with tvalid=1 after edge E+3.
//  FIFO
//  - Show-ahead; tdata is valid whenever tvalid=1 and is held stable while tvalid & ~tready.
//  - Pop on tvalid & tready.
//  - Simultaneous push and pop when full: the push succeeds (pop frees the slot) and the level is unchanged.
//  - Full without pop: the beat is dropped, overflow <= 1, drop_count += 1, saturating at all-ones.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact, 0..FIFO_DEPTH.
//  - clear_ovf together with a drop in the same cycle: overflow=1 and drop_count=1 (the drop wins over the clear).
// TESTING
//  1. N=1, shift=0, ch0 codes 14'h0000 / 14'h2000 / 14'h3FFF -> tdata lane0 16'hE000 / 16'h0000 / 16'h1FFF;
//     first tvalid 3 cycles after the first sample.
//  2. N=4, shift=2, ch0 const 14'h2010 (+16), ch1 const 14'h1FF0 (-16) -> one beat every 4 cycles,
//     lanes +16 / -16 (16'h0010 / 16'hFFF0).
//  3. N=8, shift=0, ch0 const 14'h3FFF -> sum 65528 saturates to 16'h7FFF;
//     ch0 14'h0000 -> sum -65536 saturates to 16'h8000.
//  4. N=1, tready=0 -> fifo_level reaches FIFO_DEPTH; the next 10 cycles give overflow=1, drop_count=10;
//     clear_ovf -> both 0; FIFO drains in order once tready=1.
//  5. N=4: enable drops after 2 samples, re-enabled -> the next beat sums 4 fresh samples only;
//     decim changed mid-block -> takes effect at the next block.
//  6. aresetn low 1 cycle mid-stream with full FIFO -> next cycle tvalid=0, fifo_level=0, overflow=0, drop_count=0.

Source files
------------

// File: rtl/axis_red_pitaya_adc_mc.sv
// axis_red_pitaya_adc_mc
//   Multi-channel Red Pitaya ADC AXI-Stream source. Registers NUM_CH offset-binary ADC words every
//   cycle, converts them to two's complement and boxcar-decimates them. Each block sum is
//   arithmetically shifted and saturated, then buffered in a show-ahead FIFO. The ADC side never
//   stalls, so a beat that finds the FIFO full is dropped and counted.
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   adc_in          NUM_CH packed ADC words, channel k at [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
//   enable          1 = acquire; 0 = decimator idle, FIFO still drains
//   decim, shift    samples per beat (0 acts as 1) and right shift applied to the block sum
//   clear_ovf       pulse clearing overflow and drop_count
//   m_axis_*        AXI-Stream master, channel k at [k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]
//   overflow        sticky dropped-beat flag
//   drop_count      saturating count of dropped beats
//   fifo_level      occupied FIFO entries
module axis_red_pitaya_adc_mc #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ADC_DATA_WIDTH  = 14,
  parameter int unsigned AXIS_DATA_WIDTH = 16,
  parameter int unsigned DECIM_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned COUNT_WIDTH     = 32,
  localparam int unsigned ACC_W          = ADC_DATA_WIDTH + DECIM_WIDTH,
  localparam int unsigned SHIFT_W        = $clog2(ACC_W),
  localparam int unsigned LEVEL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_CH*ADC_DATA_WIDTH-1:0]  adc_in,
  input  logic                              enable,
  input  logic [DECIM_WIDTH-1:0]            decim,
  input  logic [SHIFT_W-1:0]                shift,
  input  logic                              clear_ovf,
  output logic [NUM_CH*AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              overflow,
  output logic [COUNT_WIDTH-1:0]            drop_count,
  output logic [LEVEL_W-1:0]                fifo_level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BEAT_W = NUM_CH * AXIS_DATA_WIDTH;
  localparam int unsigned SAT_W  = (ACC_W > AXIS_DATA_WIDTH) ? ACC_W : AXIS_DATA_WIDTH;

  localparam logic signed [SAT_W-1:0] SatMax =
      {{(SAT_W - AXIS_DATA_WIDTH + 1){1'b0}}, {(AXIS_DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SatMin = ~SatMax;

  // ---------------------------------------------------------------------------------------------
  // Stage 0: capture samples. enable/decim/shift travel with the sample they were presented with.
  // ---------------------------------------------------------------------------------------------
  logic [NUM_CH*ADC_DATA_WIDTH-1:0] adc_q;
  logic                             en_q;
  logic [DECIM_WIDTH-1:0]           decim_q;
  logic [SHIFT_W-1:0]               shift_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      adc_q   <= '0;
      en_q    <= 1'b0;
      decim_q <= '0;
      shift_q <= '0;
    end else begin
      adc_q   <= adc_in;
      en_q    <= enable;
      decim_q <= decim;
      shift_q <= shift;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: conversion and accumulation
  // ---------------------------------------------------------------------------------------------
  logic [DECIM_WIDTH-1:0]   cnt_q, n_lat_q, n_req, n_eff;
  logic [SHIFT_W-1:0]       shift_lat_q, sh_eff, blk_shift_q;
  logic                     blk_end, done_q;
  logic signed [ACC_W-1:0]  acc_q [NUM_CH];
  logic signed [ACC_W-1:0]  sum_d [NUM_CH];

  always_comb begin
    n_req   = (decim_q == '0) ? DECIM_WIDTH'(1) : decim_q;
    // Ratio and shift are taken fresh only on the first sample of a block.
    n_eff   = (cnt_q == '0) ? n_req : n_lat_q;
    sh_eff  = (cnt_q == '0) ? shift_q : shift_lat_q;
    blk_end = en_q && (cnt_q == n_eff - DECIM_WIDTH'(1));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic signed [ADC_DATA_WIDTH-1:0] raw;
      logic signed [ACC_W-1:0]          conv;
      // Offset binary to two's complement: invert the MSB.
      raw  = {~adc_q[ch*ADC_DATA_WIDTH + ADC_DATA_WIDTH - 1],
              adc_q[ch*ADC_DATA_WIDTH +: ADC_DATA_WIDTH - 1]};
      conv = ACC_W'(raw);
      sum_d[ch] = (cnt_q == '0) ? conv : acc_q[ch] + conv;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      n_lat_q     <= DECIM_WIDTH'(1);
      shift_lat_q <= '0;
      blk_shift_q <= '0;
      done_q      <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
    end else begin
      done_q <= blk_end;
      if (en_q) begin
        cnt_q <= blk_end ? '0 : cnt_q + DECIM_WIDTH'(1);
        if (cnt_q == '0) begin
          n_lat_q     <= n_req;
          shift_lat_q <= shift_q;
        end
        blk_shift_q <= sh_eff;
        for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= sum_d[ch];
      end else begin
        // Idle: drop any partial block so the next one starts clean.
        cnt_q <= '0;
        for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: shift and saturate the completed block sum (acc_q holds it for one cycle)
  // ---------------------------------------------------------------------------------------------
  logic [BEAT_W-1:0] res_d, res_q;
  logic              res_vld_q;

  always_comb begin
    res_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic signed [ACC_W-1:0] shifted;
      logic signed [SAT_W-1:0] ext;
      shifted = acc_q[ch] >>> blk_shift_q;
      ext     = SAT_W'(shifted);
      if (ext > SatMax)      ext = SatMax;
      else if (ext < SatMin) ext = SatMin;
      res_d[ch*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = ext[AXIS_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      res_vld_q <= done_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output FIFO (show-ahead) with overflow accounting
  // ---------------------------------------------------------------------------------------------
  logic [BEAT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                   full, push, pop, drop;

  always_comb begin
    full = (level_q == LEVEL_W'(FIFO_DEPTH));
    pop  = (level_q != '0) && m_axis_tready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    push = res_vld_q && (!full || pop);
    drop = res_vld_q && full && !pop;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LEVEL_W'(1);
    else if (!push && pop) level_d = level_q - LEVEL_W'(1);

    // A drop in the same cycle as clear_ovf wins: the drop is the first one counted.
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clear_ovf)             drop_cnt_d = COUNT_WIDTH'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + COUNT_WIDTH'(1);
    end else if (clear_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; an empty FIFO masks its output.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= res_q;
  end

  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign overflow      = ovf_q;
  assign drop_count    = drop_cnt_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_axis_red_pitaya_adc_mc.sv
// Self-checking bench for axis_red_pitaya_adc_mc with default parameters
// (2 channels, 14-bit ADC, 16-bit lanes, 16-deep FIFO).
module tb_axis_red_pitaya_adc_mc;

  logic        aclk;
  logic        aresetn;
  logic [27:0] adc_in;
  logic        enable;
  logic [7:0]  decim;
  logic [4:0]  shift;
  logic        clear_ovf;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overflow;
  logic [31:0] drop_count;
  logic [4:0]  fifo_level;

  axis_red_pitaya_adc_mc dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .adc_in        (adc_in),
    .enable        (enable),
    .decim         (decim),
    .shift         (shift),
    .clear_ovf     (clear_ovf),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } smp_vec_t;

  typedef struct {
    logic [7:0]  decim;
    logic [4:0]  shift;
    logic [13:0] ch0;
    logic [13:0] ch1;
    int          nblk;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } blk_vec_t;

  smp_vec_t sv[5];
  blk_vec_t bv[6];

  initial begin
    // Offset binary -> two's complement, N=1
    sv[0] = '{14'h0000, 14'h2000, 16'hE000, 16'h0000};
    sv[1] = '{14'h2000, 14'h0000, 16'h0000, 16'hE000};
    sv[2] = '{14'h3FFF, 14'h1FFF, 16'h1FFF, 16'hFFFF};
    sv[3] = '{14'h0001, 14'h3000, 16'hE001, 16'h1000};
    sv[4] = '{14'h2001, 14'h2FFF, 16'h0001, 16'h0FFF};
    // Block decimation: constant inputs, expected beat value
    bv[0] = '{8'd4,   5'd2, 14'h2010, 14'h1FF0, 3, 16'h0010, 16'hFFF0};
    bv[1] = '{8'd8,   5'd0, 14'h3FFF, 14'h0000, 2, 16'h7FFF, 16'h8000};
    bv[2] = '{8'd2,   5'd1, 14'h2003, 14'h1FFD, 2, 16'h0003, 16'hFFFD};
    bv[3] = '{8'd0,   5'd0, 14'h2005, 14'h2000, 3, 16'h0005, 16'h0000};
    bv[4] = '{8'd255, 5'd5, 14'h3FFF, 14'h1FFF, 1, 16'h7FFF, 16'hFFF8};
    bv[5] = '{8'd3,   5'd0, 14'h2100, 14'h2000, 2, 16'h0300, 16'h0000};

    aresetn       = 1'b0;
    adc_in        = {14'h2000, 14'h2000};
    enable        = 1'b0;
    decim         = 8'd1;
    shift         = 5'd0;
    clear_ovf     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();

    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_count", 64'(drop_count), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    aresetn = 1'b1;
    step();

    // ---- Conversion and 3-cycle latency, N=1 ----
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        adc_in = {sv[i].ch1, sv[i].ch0};
        enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
      step();
      if (i >= 3 && i - 3 < 5) begin
        chk("conv_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("conv_tdata", 64'(m_axis_tdata), 64'({sv[i-3].exp1, sv[i-3].exp0}));
      end else begin
        chk("conv_latency_tvalid", 64'(m_axis_tvalid), 64'd0);
      end
    end

    // ---- Block decimation with shift and saturation ----
    for (int v = 0; v < 6; v++) begin
      int n;
      int total;
      n     = (bv[v].decim == 8'd0) ? 1 : int'(bv[v].decim);
      total = n * bv[v].nblk;
      decim = bv[v].decim;
      shift = bv[v].shift;
      for (int i = 0; i < total + 5; i++) begin
        int  j;
        logic expv;
        adc_in = {bv[v].ch1, bv[v].ch0};
        enable = (i < total);
        step();
        j    = i - 3;
        expv = (j >= 0) && (j < total) && ((j % n) == n - 1);
        chk($sformatf("blk%0d_tvalid", v), 64'(m_axis_tvalid), 64'(expv));
        if (expv)
          chk($sformatf("blk%0d_tdata", v), 64'(m_axis_tdata),
              64'({bv[v].exp1, bv[v].exp0}));
      end
    end

    // ---- Enable drop mid-block, then decim change mid-block ----
    shift = 5'd0;
    for (int i = 0; i < 23; i++) begin
      logic [15:0] expd;
      logic        expv;
      enable = (i < 2) || (i >= 5 && i <= 16);
      adc_in = {14'h2000, (i < 2) ? 14'h2064 : 14'h2001};
      decim  = (i >= 10) ? 8'd2 : 8'd4;
      step();
      expv = (i == 11) || (i == 15) || (i == 17) || (i == 19);
      expd = (i <= 15) ? 16'd4 : 16'd2;
      chk("endis_tvalid", 64'(m_axis_tvalid), 64'(expv));
      if (expv) chk("endis_tdata", 64'(m_axis_tdata), 64'({16'h0000, expd}));
    end

    // ---- Overflow: fill with tready=0, drops, clear-vs-drop, clear, in-order drain ----
    decim         = 8'd1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      int lvl;
      int dc;
      enable    = (i < 26);
      adc_in    = {14'h2000, 14'(14'h2000 + i + 1)};
      clear_ovf = (i == 19);
      step();
      lvl = (i < 3) ? 0 : ((i - 2 > 16) ? 16 : i - 2);
      dc  = (i < 19) ? 0 : ((i - 18 > 10) ? 10 : i - 18);
      chk("ovf_level", 64'(fifo_level), 64'(lvl));
      chk("ovf_flag", 64'(overflow), 64'(i >= 19));
      chk("ovf_drop_count", 64'(drop_count), 64'(dc));
      if (i >= 3) chk("ovf_head_stable", 64'(m_axis_tdata), 64'h1);
    end
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clear_overflow", 64'(overflow), 64'd0);
    chk("clear_drop_count", 64'(drop_count), 64'd0);
    chk("clear_level_kept", 64'(fifo_level), 64'd16);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("drain_order", 64'(m_axis_tdata), 64'(k + 1));
      chk("drain_level", 64'(fifo_level), 64'(16 - k));
      step();
    end
    chk("drain_empty", 64'(m_axis_tvalid), 64'd0);

    // ---- Push+pop when full, drops, then reset with a full FIFO ----
    for (int i = 0; i < 23; i++) begin
      enable        = (i < 20);
      adc_in        = {14'h2000, 14'(14'h2000 + i + 1)};
      m_axis_tready = (i == 19);
      step();
      if (i == 18) begin
        chk("full_level", 64'(fifo_level), 64'd16);
        chk("full_no_ovf", 64'(overflow), 64'd0);
      end
      if (i == 19) begin
        chk("pushpop_level", 64'(fifo_level), 64'd16);
        chk("pushpop_no_ovf", 64'(overflow), 64'd0);
        chk("pushpop_no_drop", 64'(drop_count), 64'd0);
        chk("pushpop_head", 64'(m_axis_tdata), 64'd2);
      end
      if (i == 22) begin
        chk("pre_reset_ovf", 64'(overflow), 64'd1);
        chk("pre_reset_drops", 64'(drop_count), 64'd3);
      end
    end
    aresetn = 1'b0;
    step();
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    repeat (4) step();
    chk("post_reset_idle", 64'(m_axis_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
